reg_file_mp: RTL and testbench

//  Parametrised multi-port ARM register file: generalised successor of reg_sync.

---
 rtl/reg_file_mp_pkg.sv | 21 ++
 rtl/reg_file_mp_if.sv | 35 +++
 rtl/reg_file_wr_arb.sv | 25 ++
 rtl/reg_file_mp.sv | 128 ++++++++++++
 tb/tb_reg_file_mp.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared sizing, PC alias index and reset constants for the multi-port register file.
package reg_file_mp_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int NUM_RD   = 3;
  localparam int NUM_WR   = 4;
  localparam int PC_STEP  = 4;
  localparam int PC_IDX   = NUM_REGS - 1;

  localparam logic [DATA_W-1:0]   RST_WORD = {DATA_W{1'b0}};
  localparam logic [NUM_REGS-1:0] RST_BUSY = {NUM_REGS{1'b0}};
  localparam logic [NUM_RD-1:0]   RST_VLD  = {NUM_RD{1'b0}};

  // True when a packed address field selects register r.
  function automatic logic addr_is(input logic [ADDR_W-1:0] addr, input int r);
    return (addr == ADDR_W'(r));
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Issue-side bus of the register file: read/write/reserve ports, PC and CPSR controls.
interface reg_file_mp_if;
  import reg_file_mp_pkg::*;

  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_valid;
  logic [NUM_WR-1:0]          wr_en;
  logic [NUM_WR*ADDR_W-1:0]   wr_addr;
  logic [NUM_WR*DATA_W-1:0]   wr_data;
  logic [NUM_WR-1:0]          rsv_en;
  logic [NUM_WR*ADDR_W-1:0]   rsv_addr;
  logic [NUM_REGS-1:0]        busy;
  logic                       pc_write;
  logic [DATA_W-1:0]          pc_update;
  logic                       pc_inc;
  logic [DATA_W-1:0]          pc;
  logic                       cpsr_write;
  logic [DATA_W-1:0]          cpsr_update;
  logic [DATA_W-1:0]          cpsr;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
           pc_write, pc_update, pc_inc, cpsr_write, cpsr_update,
    input  rd_data, rd_valid, busy, pc, cpsr
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
           pc_write, pc_update, pc_inc, cpsr_write, cpsr_update,
    output rd_data, rd_valid, busy, pc, cpsr
  );

endinterface

// File: rtl/reg_file_wr_arb.sv
// Per-register write-port select: the highest-indexed enabled port addressing a register wins.
module reg_file_wr_arb
  import reg_file_mp_pkg::*;
(
  input  logic [NUM_WR-1:0]                    wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0]             wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]             wr_data_i,
  output logic [NUM_REGS-1:0]                  hit_o,
  output logic [NUM_REGS-1:0][DATA_W-1:0]      data_o
);

  // Ascending port scan so later (higher) ports overwrite earlier selections.
  always_comb begin
    hit_o  = RST_BUSY;
    data_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        hit_o[r]  = hit_o[r] | (wr_en_i[w] & addr_is(wr_addr_i[w*ADDR_W +: ADDR_W], r));
        data_o[r] = (wr_en_i[w] & addr_is(wr_addr_i[w*ADDR_W +: ADDR_W], r))
                    ? wr_data_i[w*DATA_W +: DATA_W] : data_o[r];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with PC alias, CPSR, busy scoreboard and registered read ports.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle write data to reads.
module reg_file_mp (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_mp_if.slave bus
);
  import reg_file_mp_pkg::*;

  logic [NUM_REGS-1:0]              wr_hit_s;
  logic [NUM_REGS-1:0][DATA_W-1:0]  wr_sel_s;
  logic [NUM_REGS-1:0]              rsv_hit_s;
  logic [NUM_REGS-1:0][DATA_W-1:0]  view_s;
  logic [NUM_REGS-1:0][DATA_W-1:0]  src_s;
  logic [NUM_REGS-1:0]              ok_s;
  logic [PC_IDX-1:0][DATA_W-1:0]    regs_q, regs_d;
  logic [NUM_REGS-1:0]              busy_q, busy_d;
  logic [DATA_W-1:0]                pc_q, pc_d, cpsr_q, cpsr_d;
  logic [NUM_RD-1:0][DATA_W-1:0]    rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]                rd_valid_q, rd_valid_d;

  reg_file_wr_arb u_wr_arb (
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .hit_o     (wr_hit_s),
    .data_o    (wr_sel_s)
  );

  // Architectural view of every readable index; the top index aliases the PC.
  always_comb begin
    view_s = '0;
    for (int r = 0; r < PC_IDX; r++) begin
      view_s[r] = regs_q[r];
    end
    view_s[PC_IDX] = pc_q;
  end

`ifdef REG_FILE_MP_BYPASS_EN
  // A same-cycle write supplies the read and resolves a pending reservation.
  always_comb begin
    src_s = view_s;
    for (int r = 0; r < PC_IDX; r++) begin
      src_s[r] = wr_hit_s[r] ? wr_sel_s[r] : view_s[r];
    end
    if (bus.pc_write) begin
      src_s[PC_IDX] = bus.pc_update;
    end else begin
      src_s[PC_IDX] = wr_hit_s[PC_IDX] ? wr_sel_s[PC_IDX] : pc_q;
    end
    ok_s = ~busy_q | wr_hit_s;
  end
`else
  assign src_s = view_s;
  assign ok_s  = ~busy_q;
`endif

  // Reservation decode; the PC index is never reservable.
  always_comb begin
    rsv_hit_s = RST_BUSY;
    for (int r = 0; r < PC_IDX; r++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        rsv_hit_s[r] = rsv_hit_s[r] | (bus.rsv_en[w] & addr_is(bus.rsv_addr[w*ADDR_W +: ADDR_W], r));
      end
    end
  end

  // Next state: storage, scoreboard (reserve beats clear), PC priority chain, CPSR.
  always_comb begin
    busy_d = RST_BUSY;
    regs_d = regs_q;
    for (int r = 0; r < PC_IDX; r++) begin
      busy_d[r] = rsv_hit_s[r] | (busy_q[r] & ~wr_hit_s[r]);
      regs_d[r] = wr_hit_s[r] ? wr_sel_s[r] : regs_q[r];
    end
    if (bus.pc_write) begin
      pc_d = bus.pc_update;
    end else if (wr_hit_s[PC_IDX]) begin
      pc_d = wr_sel_s[PC_IDX];
    end else if (bus.pc_inc) begin
      pc_d = pc_q + DATA_W'(PC_STEP);
    end else begin
      pc_d = pc_q;
    end
    cpsr_d = bus.cpsr_write ? bus.cpsr_update : cpsr_q;
  end

  // Read ports: stall on busy, hold data whenever no valid result is produced.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = RST_VLD;
    for (int p = 0; p < NUM_RD; p++) begin
      if (bus.rd_en[p] && ok_s[bus.rd_addr[p*ADDR_W +: ADDR_W]]) begin
        rd_data_d[p]  = src_s[bus.rd_addr[p*ADDR_W +: ADDR_W]];
        rd_valid_d[p] = 1'b1;
      end else begin
        rd_data_d[p]  = rd_data_q[p];
        rd_valid_d[p] = 1'b0;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '0;
      busy_q     <= RST_BUSY;
      pc_q       <= RST_WORD;
      cpsr_q     <= RST_WORD;
      rd_data_q  <= '0;
      rd_valid_q <= RST_VLD;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      pc_q       <= pc_d;
      cpsr_q     <= cpsr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
  assign bus.pc       = pc_q;
  assign bus.cpsr     = cpsr_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic against a reference model.
module tb_reg_file_mp;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  reg_file_mp_if bus ();

  reg_file_mp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [31:0] m_regs [15];
  logic [31:0] m_pc;
  logic [31:0] m_cpsr;
  logic [15:0] m_busy;
  logic [31:0] m_rd_data [3];
  logic [2:0]  m_rd_valid;

  task automatic model_reset();
    for (int r = 0; r < 15; r++) m_regs[r] = 32'h0;
    m_pc = 32'h0;
    m_cpsr = 32'h0;
    m_busy = 16'h0;
    for (int p = 0; p < 3; p++) m_rd_data[p] = 32'h0;
    m_rd_valid = 3'b000;
  endtask

  task automatic clear_inputs();
    bus.rd_en = 3'b000;
    bus.rd_addr = 12'h0;
    bus.wr_en = 4'b0000;
    bus.wr_addr = 16'h0;
    bus.wr_data = 128'h0;
    bus.rsv_en = 4'b0000;
    bus.rsv_addr = 16'h0;
    bus.pc_write = 1'b0;
    bus.pc_update = 32'h0;
    bus.pc_inc = 1'b0;
    bus.cpsr_write = 1'b0;
    bus.cpsr_update = 32'h0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic [31:0] n_regs [15];
    logic [15:0] n_busy;
    logic [15:0] written;
    logic [31:0] n_pc;
    logic [31:0] pc_port_val;
    logic        pc_port_hit;
    logic [3:0]  a;
    logic [31:0] rv;
    logic        ok;
    if (rst_n) begin
      for (int r = 0; r < 15; r++) n_regs[r] = m_regs[r];
      written = 16'h0;
      pc_port_hit = 1'b0;
      pc_port_val = 32'h0;
      for (int w = 0; w < 4; w++) begin
        if (bus.wr_en[w]) begin
          a = bus.wr_addr[w*4 +: 4];
          written[a] = 1'b1;
          if (a == 4'd15) begin
            pc_port_hit = 1'b1;
            pc_port_val = bus.wr_data[w*32 +: 32];
          end else begin
            n_regs[a] = bus.wr_data[w*32 +: 32];
          end
        end
      end
      n_busy = m_busy & ~written;
      for (int w = 0; w < 4; w++) begin
        a = bus.rsv_addr[w*4 +: 4];
        if (bus.rsv_en[w] && a != 4'd15) n_busy[a] = 1'b1;
      end
      n_pc = m_pc;
      if (bus.pc_inc) n_pc = m_pc + 32'd4;
      if (pc_port_hit) n_pc = pc_port_val;
      if (bus.pc_write) n_pc = bus.pc_update;
      for (int p = 0; p < 3; p++) begin
        a = bus.rd_addr[p*4 +: 4];
        rv = (a == 4'd15) ? m_pc : m_regs[a];
        ok = (a == 4'd15) ? 1'b1 : !m_busy[a];
`ifdef REG_FILE_MP_BYPASS_EN
        if (a == 4'd15) begin
          if (bus.pc_write) rv = bus.pc_update;
          else if (pc_port_hit) rv = pc_port_val;
        end else if (written[a]) begin
          rv = n_regs[a];
          ok = 1'b1;
        end
`endif
        if (bus.rd_en[p] && ok) begin
          m_rd_data[p] = rv;
          m_rd_valid[p] = 1'b1;
        end else begin
          m_rd_valid[p] = 1'b0;
        end
      end
      for (int r = 0; r < 15; r++) m_regs[r] = n_regs[r];
      m_busy = n_busy;
      m_pc = n_pc;
      if (bus.cpsr_write) m_cpsr = bus.cpsr_update;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.wr_en[0] = 1'b1;
    bus.wr_data[31:0] = 32'h5A5A_0001;
    bus.rd_en = 3'b111;
    bus.pc_inc = 1'b1;
    bus.cpsr_write = 1'b1;
    bus.cpsr_update = 32'hFFFF_FFFF;
    tick();
    tick();
    checks++;
    if (bus.rd_data !== 96'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    checks++;
    if (bus.rd_valid !== 3'b000) begin errors++; $display("FAIL reset_rd_valid: got %b want 000", bus.rd_valid); end
    checks++;
    if (bus.busy !== 16'h0 || bus.pc !== 32'h0 || bus.cpsr !== 32'h0) begin
      errors++; $display("FAIL reset_state: busy %h pc %h cpsr %h want all 0", bus.busy, bus.pc, bus.cpsr);
    end
    rst_n = 1'b1;
    clear_inputs();
    bus.wr_en[0] = 1'b1;
    bus.wr_data[31:0] = 32'h5A5A_0001;
    tick();
    clear_inputs();
    bus.rd_en[0] = 1'b1;
    tick();
    checks++;
    if (bus.rd_data[31:0] !== 32'h5A5A_0001 || bus.rd_valid[0] !== 1'b1) begin
      errors++; $display("FAIL reset_first_read: got %h/%b want 5a5a0001/1", bus.rd_data[31:0], bus.rd_valid[0]);
    end
  endtask

  task automatic test_write_read();
    clear_inputs();
    bus.wr_en = 4'b0011;
    bus.wr_addr[3:0] = 4'd0;
    bus.wr_addr[7:4] = 4'd1;
    bus.wr_data[31:0] = 32'h2;
    bus.wr_data[63:32] = 32'h1;
    tick();
    clear_inputs();
    bus.rd_en = 3'b011;
    bus.rd_addr[3:0] = 4'd0;
    bus.rd_addr[7:4] = 4'd1;
    tick();
    checks++;
    if (bus.rd_data[31:0] !== 32'h2 || bus.rd_data[63:32] !== 32'h1) begin
      errors++; $display("FAIL write_read_data: got %h/%h want 2/1", bus.rd_data[31:0], bus.rd_data[63:32]);
    end
    checks++;
    if (bus.rd_valid !== 3'b011) begin errors++; $display("FAIL write_read_valid: got %b want 011", bus.rd_valid); end
    clear_inputs();
    tick();
    checks++;
    if (bus.rd_valid !== 3'b000 || bus.rd_data[31:0] !== 32'h2) begin
      errors++; $display("FAIL idle_hold: valid %b data0 %h want 000/2", bus.rd_valid, bus.rd_data[31:0]);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    bus.wr_en = 4'b1010;
    bus.wr_addr[7:4] = 4'd2;
    bus.wr_addr[15:12] = 4'd2;
    bus.wr_data[63:32] = 32'hAA;
    bus.wr_data[127:96] = 32'hBB;
    tick();
    clear_inputs();
    bus.rd_en[2] = 1'b1;
    bus.rd_addr[11:8] = 4'd2;
    tick();
    checks++;
    if (bus.rd_data[95:64] !== 32'hBB || bus.rd_valid[2] !== 1'b1) begin
      errors++; $display("FAIL write_priority: got %h/%b want bb/1", bus.rd_data[95:64], bus.rd_valid[2]);
    end
  endtask

  task automatic test_busy();
    clear_inputs();
    bus.rsv_en[0] = 1'b1;
    bus.rsv_addr[3:0] = 4'd2;
    bus.rsv_en[1] = 1'b1;
    bus.rsv_addr[7:4] = 4'd15;
    tick();
    checks++;
    if (bus.busy !== 16'h0004) begin errors++; $display("FAIL busy_set: got %h want 0004", bus.busy); end
    clear_inputs();
    bus.rd_en[0] = 1'b1;
    bus.rd_addr[3:0] = 4'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.rd_valid[0] !== 1'b0 || bus.rd_data[31:0] !== 32'h2) begin
        errors++; $display("FAIL busy_stall%0d: got %b/%h want 0/2", i, bus.rd_valid[0], bus.rd_data[31:0]);
      end
    end
    bus.wr_en[2] = 1'b1;
    bus.wr_addr[11:8] = 4'd2;
    bus.wr_data[95:64] = 32'h6;
    tick();
    checks++;
`ifdef REG_FILE_MP_BYPASS_EN
    if (bus.rd_valid[0] !== 1'b1 || bus.rd_data[31:0] !== 32'h6) begin
      errors++; $display("FAIL busy_write_cycle: got %b/%h want 1/6", bus.rd_valid[0], bus.rd_data[31:0]);
    end
`else
    if (bus.rd_valid[0] !== 1'b0 || bus.rd_data[31:0] !== 32'h2) begin
      errors++; $display("FAIL busy_write_cycle: got %b/%h want 0/2", bus.rd_valid[0], bus.rd_data[31:0]);
    end
`endif
    bus.wr_en = 4'b0000;
    tick();
    checks++;
    if (bus.rd_valid[0] !== 1'b1 || bus.rd_data[31:0] !== 32'h6 || bus.busy !== 16'h0) begin
      errors++; $display("FAIL busy_release: got %b/%h busy %h want 1/6/0", bus.rd_valid[0], bus.rd_data[31:0], bus.busy);
    end
    clear_inputs();
    bus.rsv_en[3] = 1'b1;
    bus.rsv_addr[15:12] = 4'd4;
    bus.wr_en[0] = 1'b1;
    bus.wr_addr[3:0] = 4'd4;
    bus.wr_data[31:0] = 32'h44;
    tick();
    checks++;
    if (bus.busy !== 16'h0010) begin errors++; $display("FAIL busy_set_wins: got %h want 0010", bus.busy); end
    clear_inputs();
    bus.wr_en[1] = 1'b1;
    bus.wr_addr[7:4] = 4'd4;
    tick();
    checks++;
    if (bus.busy !== 16'h0) begin errors++; $display("FAIL busy_clear: got %h want 0000", bus.busy); end
  endtask

  task automatic test_pc();
    clear_inputs();
    bus.pc_write = 1'b1;
    bus.pc_update = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    bus.pc_inc = 1'b1;
    tick();
    checks++;
    if (bus.pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h want 0", bus.pc); end
    bus.pc_write = 1'b1;
    bus.pc_update = 32'h100;
    bus.wr_en[2] = 1'b1;
    bus.wr_addr[11:8] = 4'd15;
    bus.wr_data[95:64] = 32'h55;
    tick();
    checks++;
    if (bus.pc !== 32'h100) begin errors++; $display("FAIL pc_write_prio: got %h want 100", bus.pc); end
    bus.pc_write = 1'b0;
    bus.wr_data[95:64] = 32'h200;
    tick();
    checks++;
    if (bus.pc !== 32'h200) begin errors++; $display("FAIL pc_port_prio: got %h want 200", bus.pc); end
    clear_inputs();
    bus.pc_inc = 1'b1;
    bus.cpsr_write = 1'b1;
    bus.cpsr_update = 32'hF000_00D3;
    tick();
    clear_inputs();
    bus.rd_en[1] = 1'b1;
    bus.rd_addr[7:4] = 4'd15;
    tick();
    checks++;
    if (bus.rd_data[63:32] !== 32'h204 || bus.rd_valid[1] !== 1'b1 || bus.cpsr !== 32'hF000_00D3) begin
      errors++; $display("FAIL pc_read_cpsr: rd %h/%b cpsr %h want 204/1/f00000d3", bus.rd_data[63:32], bus.rd_valid[1], bus.cpsr);
    end
  endtask

  task automatic test_same_cycle();
    clear_inputs();
    bus.wr_en[0] = 1'b1;
    bus.wr_addr[3:0] = 4'd3;
    bus.wr_data[31:0] = 32'h5;
    tick();
    bus.wr_en = 4'b0000;
    bus.wr_en[3] = 1'b1;
    bus.wr_addr[15:12] = 4'd3;
    bus.wr_data[127:96] = 32'h9;
    bus.rd_en[1] = 1'b1;
    bus.rd_addr[7:4] = 4'd3;
    tick();
    checks++;
`ifdef REG_FILE_MP_BYPASS_EN
    if (bus.rd_data[63:32] !== 32'h9) begin errors++; $display("FAIL same_cycle_rw: got %h want 9", bus.rd_data[63:32]); end
`else
    if (bus.rd_data[63:32] !== 32'h5) begin errors++; $display("FAIL same_cycle_rw: got %h want 5", bus.rd_data[63:32]); end
`endif
    bus.wr_en = 4'b0000;
    tick();
    checks++;
    if (bus.rd_data[63:32] !== 32'h9) begin errors++; $display("FAIL after_write_read: got %h want 9", bus.rd_data[63:32]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.rd_en = 3'($urandom);
      bus.rd_addr = {4'($urandom), 4'($urandom), 4'($urandom)};
      bus.wr_en = 4'($urandom) & 4'($urandom);
      bus.wr_addr = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
      bus.rsv_en = 4'($urandom) & 4'($urandom) & 4'($urandom);
      bus.rsv_addr = {4'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom)};
      bus.pc_write = ($urandom_range(0, 15) == 0);
      bus.pc_update = $urandom;
      bus.pc_inc = 1'($urandom);
      bus.cpsr_write = ($urandom_range(0, 7) == 0);
      bus.cpsr_update = $urandom;
      tick();
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (bus.rd_valid[p] !== m_rd_valid[p]) begin
          errors++; $display("FAIL rand_valid%0d cyc %0d: got %b want %b", p, c, bus.rd_valid[p], m_rd_valid[p]);
        end
        checks++;
        if (bus.rd_data[p*32 +: 32] !== m_rd_data[p]) begin
          errors++; $display("FAIL rand_data%0d cyc %0d: got %h want %h", p, c, bus.rd_data[p*32 +: 32], m_rd_data[p]);
        end
      end
      checks++;
      if (bus.busy !== m_busy) begin errors++; $display("FAIL rand_busy cyc %0d: got %h want %h", c, bus.busy, m_busy); end
      checks++;
      if (bus.pc !== m_pc) begin errors++; $display("FAIL rand_pc cyc %0d: got %h want %h", c, bus.pc, m_pc); end
      checks++;
      if (bus.cpsr !== m_cpsr) begin errors++; $display("FAIL rand_cpsr cyc %0d: got %h want %h", c, bus.cpsr, m_cpsr); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_priority();
    test_busy();
    test_pc();
    test_same_cycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
